// File: rtl/context_switch_scheduler_if.sv
// rtl/context_switch_scheduler_if.sv - CPU, RAM and register-file signals of the context switch scheduler
// Purpose: bundles every non-clock/reset signal of context_switch_scheduler.
// Modports:
//   master : scheduler side (drives RAM/register/PC controls and status)
//   slave  : CPU/RAM environment side
interface context_switch_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  enable;
  logic                  instr_retired;
  logic                  halt_in;
  logic [DATA_WIDTH-1:0] pc_in;
  logic [DATA_WIDTH-1:0] reg_rdata;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;
  logic [4:0]            reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic                  reg_we;
  logic [DATA_WIDTH-1:0] pc_out;
  logic                  pc_load;
  logic                  cpu_stall;
  logic [1:0]            programa;
  logic                  all_halted;
  logic [15:0]           switch_count;

  modport master (
    input  enable, instr_retired, halt_in, pc_in, reg_rdata, ram_q,
    output ram_addr, ram_wdata, ram_we, reg_addr, reg_wdata, reg_we,
    output pc_out, pc_load, cpu_stall, programa, all_halted, switch_count
  );

  modport slave (
    output enable, instr_retired, halt_in, pc_in, reg_rdata, ram_q,
    input  ram_addr, ram_wdata, ram_we, reg_addr, reg_wdata, reg_we,
    input  pc_out, pc_load, cpu_stall, programa, all_halted, switch_count
  );
endinterface

// File: rtl/context_switch_scheduler.sv
// rtl/context_switch_scheduler.sv - time-sliced context switch scheduler for two programs
// Purpose: runs program 1 or 2 for QUANTUM enabled cycles, then saves the register
//   file and PC of the running program into its RAM partition and restores the other.
// Optional feature: define CTX_SWITCH_COUNT_EN to build the completed-switch counter.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : context_switch_scheduler_if.master
//             in  enable, instr_retired, halt_in, pc_in, reg_rdata, ram_q
//             out ram_addr/ram_wdata/ram_we, reg_addr/reg_wdata/reg_we, pc_out/pc_load,
//                 cpu_stall, programa, all_halted, switch_count
module context_switch_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int PART_SIZE  = 1000,
  parameter int PC_SLOT    = 32,
  parameter int QUANTUM    = 1000,
  parameter int ENTRY_PC2  = 0
) (
  input logic                        clock,
  input logic                        reset_n,
  context_switch_scheduler_if.master bus
);
  localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam int IW = $clog2(NUM_REGS + 2);
  localparam logic [CW-1:0] CNT_LAST      = CW'(QUANTUM - 1);
  localparam logic [IW-1:0] IDX_SAVE_LAST = IW'(NUM_REGS - 1);
  localparam logic [IW-1:0] IDX_LOAD_LAST = IW'(NUM_REGS);

  typedef enum logic [2:0] {
    S_RUN, S_SAVE_REGS, S_SAVE_PC, S_LOAD_REGS, S_LOAD_PC, S_HALTED
  } state_t;

  state_t                r_state, w_next_state;
  logic [1:0]            r_prog;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic                  r_halted1, r_halted2, r_started2;
  logic [1:0]            w_other;
  logic                  w_other_halted, w_expire, w_first2, w_entry2;
  logic [ADDR_WIDTH-1:0] w_base;

  assign w_other        = (r_prog == 2'd1) ? 2'd2 : 2'd1;
  assign w_other_halted = (r_prog == 2'd1) ? r_halted2 : r_halted1;
  assign w_expire       = bus.enable && bus.instr_retired && (r_cnt == CNT_LAST);
  // Target of the pending switch is program 2 and it has never run yet.
  assign w_first2       = (w_other == 2'd2) && !r_started2;
  // Inside LOAD_PC r_prog already names the new program.
  assign w_entry2       = (r_prog == 2'd2) && !r_started2;
  // r_prog is the old program during SAVE_* and the new one during LOAD_*.
  assign w_base         = ADDR_WIDTH'(r_prog) * ADDR_WIDTH'(PART_SIZE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_RUN;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RUN: begin
        if (bus.halt_in)
          w_next_state = w_other_halted ? S_HALTED : (w_first2 ? S_LOAD_PC : S_LOAD_REGS);
        else if (w_expire && !w_other_halted)
          w_next_state = S_SAVE_REGS;
      end
      S_SAVE_REGS: if (r_idx == IDX_SAVE_LAST) w_next_state = S_SAVE_PC;
      S_SAVE_PC:   w_next_state = w_first2 ? S_LOAD_PC : S_LOAD_REGS;
      S_LOAD_REGS: if (r_idx == IDX_LOAD_LAST) w_next_state = S_LOAD_PC;
      S_LOAD_PC:   if (w_entry2 || r_idx != '0) w_next_state = S_RUN;
      S_HALTED:    w_next_state = S_HALTED;
      default:     w_next_state = S_RUN;
    endcase
  end

  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_we    = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;
    bus.reg_we    = 1'b0;
    bus.pc_out    = '0;
    bus.pc_load   = 1'b0;
    case (r_state)
      S_SAVE_REGS: begin
        bus.reg_addr  = 5'(r_idx);
        bus.ram_addr  = w_base + ADDR_WIDTH'(r_idx);
        bus.ram_wdata = bus.reg_rdata;
        bus.ram_we    = 1'b1;
      end
      S_SAVE_PC: begin
        bus.ram_addr  = w_base + ADDR_WIDTH'(PC_SLOT);
        bus.ram_wdata = bus.pc_in;
        bus.ram_we    = 1'b1;
      end
      S_LOAD_REGS: begin
        // Read of word i overlaps the register write of word i-1 (RAM has one cycle latency).
        if (r_idx != IDX_LOAD_LAST) bus.ram_addr = w_base + ADDR_WIDTH'(r_idx);
        if (r_idx != '0) begin
          bus.reg_addr  = 5'(r_idx - IW'(1));
          bus.reg_wdata = bus.ram_q;
          bus.reg_we    = 1'b1;
        end
      end
      S_LOAD_PC: begin
        if (w_entry2) begin
          bus.pc_out  = DATA_WIDTH'(ENTRY_PC2);
          bus.pc_load = 1'b1;
        end else if (r_idx == '0) begin
          bus.ram_addr = w_base + ADDR_WIDTH'(PC_SLOT);
        end else begin
          bus.pc_out  = bus.ram_q;
          bus.pc_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.cpu_stall  = (r_state != S_RUN);
  assign bus.programa   = r_prog;
  assign bus.all_halted = (r_state == S_HALTED);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prog     <= 2'd1;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_halted1  <= 1'b0;
      r_halted2  <= 1'b0;
      r_started2 <= 1'b0;
    end else begin
      r_idx <= (w_next_state == r_state) ? r_idx + IW'(1) : '0;
      // Expiry with the other program halted simply restarts the slice.
      if (r_state != S_RUN || bus.halt_in || w_expire)
        r_cnt <= '0;
      else if (bus.enable && r_cnt != CNT_LAST)
        r_cnt <= r_cnt + CW'(1);
      if (r_state == S_RUN && bus.halt_in) begin
        if (r_prog == 2'd2) r_halted2 <= 1'b1;
        else                r_halted1 <= 1'b1;
      end
      if ((r_state == S_RUN && bus.halt_in && !w_other_halted) || r_state == S_SAVE_PC)
        r_prog <= w_other;
      if (r_state == S_LOAD_PC && w_next_state == S_RUN && r_prog == 2'd2)
        r_started2 <= 1'b1;
    end
  end

`ifdef CTX_SWITCH_COUNT_EN
  logic [15:0] r_switch_count;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_switch_count <= '0;
    else if (r_state == S_LOAD_PC && w_next_state == S_RUN)
      r_switch_count <= r_switch_count + 16'd1;
  end
  assign bus.switch_count = r_switch_count;
`else
  assign bus.switch_count = 16'd0;
`endif
endmodule

// File: tb/tb_context_switch_scheduler.sv
// tb/tb_context_switch_scheduler.sv - randomized bench for context_switch_scheduler
module tb_context_switch_scheduler;
  localparam int NR = 32;
  localparam int PS = 1000;
  localparam int PCS = 32;
  localparam int Q = 1000;
  localparam logic [31:0] EPC2 = 32'h0000_4A00;

  typedef struct {
    logic        stall;
    logic        ram_we;
    logic        ram_rd;
    logic [31:0] addr;
    logic        reg_we;
    logic [4:0]  raddr;
    logic        pc_load;
    logic [31:0] pc;
    logic [1:0]  prog;
    logic        save_pc;
    logic        fin;
  } exp_t;

  logic clock, reset_n;
  context_switch_scheduler_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  context_switch_scheduler #(.ENTRY_PC2(EPC2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [31:0] cpu_regs [32];
  logic [31:0] ram [4096];
  logic [31:0] pend_q;
  assign bus.reg_rdata = cpu_regs[bus.reg_addr];

  exp_t        q[$];
  int          m_prog, m_elapsed, m_switches, m_pos;
  bit          m_halted [1:2];
  bit          m_started2, m_dead;
  logic [31:0] ctx_regs [1:2][32];
  logic [31:0] ctx_pc [1:2];
  int          chk_old, chk_tgt;
  bit          chk_full, chk_load;
  int          p_en, p_ir;
  bit          p_halt, p_abort, aborted;
  int          checks, errors;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 50) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] base(input int p);
    return 32'(p * PS);
  endfunction

  function automatic exp_t blank(input int p);
    exp_t e;
    e = '{stall: 1'b1, ram_we: 1'b0, ram_rd: 1'b0, addr: 32'd0, reg_we: 1'b0, raddr: 5'd0,
          pc_load: 1'b0, pc: 32'd0, prog: 2'(p), save_pc: 1'b0, fin: 1'b0};
    return e;
  endfunction

  function automatic logic [15:0] exp_sc();
`ifdef CTX_SWITCH_COUNT_EN
    return 16'(m_switches);
`else
    return 16'd0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_prog = 1; m_elapsed = 0; m_switches = 0; m_pos = 0;
    m_halted[1] = 0; m_halted[2] = 0; m_started2 = 0; m_dead = 0;
    chk_full = 0; chk_load = 0;
  endtask

  // Expected stall-cycle sequence of one switch, derived from the save/restore rules.
  task automatic build_switch(input int old, input bit full);
    exp_t e;
    int tgt;
    tgt = 3 - old;
    chk_old = old; chk_tgt = tgt; chk_full = full; m_pos = 0;
    if (full) begin
      for (int i = 0; i < NR; i++) begin
        ctx_regs[old][i] = cpu_regs[i];
        e = blank(old); e.ram_we = 1; e.addr = base(old) + 32'(i); q.push_back(e);
      end
      e = blank(old); e.ram_we = 1; e.addr = base(old) + 32'(PCS); e.save_pc = 1; q.push_back(e);
    end
    if (tgt == 2 && !m_started2) begin
      chk_load = 0;
      e = blank(tgt); e.pc_load = 1; e.pc = EPC2; e.fin = 1; q.push_back(e);
      m_started2 = 1;
    end else begin
      chk_load = 1;
      for (int i = 0; i <= NR; i++) begin
        e = blank(tgt); e.ram_rd = (i < NR); e.addr = base(tgt) + 32'(i);
        e.reg_we = (i > 0); e.raddr = 5'(i - 1); q.push_back(e);
      end
      e = blank(tgt); e.ram_rd = 1; e.addr = base(tgt) + 32'(PCS); q.push_back(e);
      e = blank(tgt); e.pc_load = 1; e.pc = ctx_pc[tgt]; e.fin = 1; q.push_back(e);
    end
    m_prog = tgt;
    m_elapsed = 0;
  endtask

  task automatic model_decide();
    if (bus.halt_in) begin
      m_halted[m_prog] = 1;
      if (m_halted[3 - m_prog]) m_dead = 1;
      else build_switch(m_prog, 0);
    end else if (bus.enable && bus.instr_retired && m_elapsed >= Q - 1) begin
      if (m_halted[3 - m_prog]) m_elapsed = 0;
      else build_switch(m_prog, 1);
    end else if (bus.enable) begin
      m_elapsed++;
    end
  endtask

  task automatic step();
    exp_t e;
    bit run;
    int n;
    @(posedge clock);
    #1;
    bus.ram_q = pend_q;
    if (p_abort && q.size() != 0 && chk_full && m_pos == 10) begin
      reset_n = 1'b0;
      #1;
      check("abort_state", 64'({bus.cpu_stall, bus.programa, bus.ram_we, bus.reg_we}),
            64'({1'b0, 2'd1, 1'b0, 1'b0}));
      p_abort = 0;
      aborted = 1;
      return;
    end
    run = (q.size() == 0) && !m_dead;
    bus.enable        = ($urandom_range(99) < p_en);
    bus.instr_retired = ($urandom_range(99) < p_ir);
    bus.pc_in         = $urandom;
    bus.halt_in       = run && p_halt;
    if (bus.halt_in) p_halt = 0;
    if (run) cpu_regs[$urandom_range(31)] = $urandom;
    @(negedge clock);
    if (run) begin
      e = blank(m_prog); e.stall = 0;
    end else if (m_dead) begin
      e = blank(m_prog);
    end else begin
      e = q.pop_front();
      m_pos++;
    end
    check("ctl", 64'({bus.switch_count, bus.cpu_stall, bus.ram_we, bus.reg_we, bus.pc_load,
                      bus.programa, bus.all_halted}),
          64'({exp_sc(), e.stall, e.ram_we, e.reg_we, e.pc_load, e.prog, m_dead}));
    if (e.ram_we || e.ram_rd) check("ram_addr", 64'(bus.ram_addr), 64'(e.addr));
    if (e.reg_we) check("reg_addr", 64'(bus.reg_addr), 64'(e.raddr));
    if (e.pc_load) check("pc_out", 64'(bus.pc_out), 64'(e.pc));
    if (e.save_pc) ctx_pc[chk_old] = bus.pc_in;
    if (bus.ram_we) ram[bus.ram_addr[11:0]] = bus.ram_wdata;
    if (bus.reg_we) cpu_regs[bus.reg_addr] = bus.reg_wdata;
    pend_q = ram[bus.ram_addr[11:0]];
    if (e.fin) begin
      if (chk_full) begin
        n = 0;
        for (int i = 0; i < NR; i++) if (ram[base(chk_old) + 32'(i)] !== ctx_regs[chk_old][i]) n++;
        if (ram[base(chk_old) + 32'(PCS)] !== ctx_pc[chk_old]) n++;
        check("save_image", 64'(n), 64'd0);
      end
      if (chk_load) begin
        n = 0;
        for (int i = 0; i < NR; i++) if (cpu_regs[i] !== ctx_regs[chk_tgt][i]) n++;
        check("load_regs", 64'(n), 64'd0);
      end
      m_switches++;
    end
    if (run) model_decide();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.enable = 0; bus.instr_retired = 0; bus.halt_in = 0; bus.pc_in = '0; bus.ram_q = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ctl", 64'({bus.switch_count, bus.cpu_stall, bus.ram_we, bus.reg_we, bus.pc_load,
                          bus.programa, bus.all_halted}), 64'({16'd0, 4'b0, 2'd1, 1'b0}));
    check("rst_addr_pc", {bus.ram_addr, bus.pc_out}, 64'd0);
    check("rst_wdata", {bus.ram_wdata, bus.reg_wdata}, 64'd0);
    reset_n = 1'b1;
    model_reset();
    pend_q = '0;
  endtask

  initial begin
    checks = 0; errors = 0;
    p_halt = 0; p_abort = 0; aborted = 0;
    for (int i = 0; i < 4096; i++) ram[i] = '0;
    for (int i = 0; i < 32; i++) cpu_regs[i] = $urandom;
    do_reset();

    // Back-to-back full-rate slices: first switch enters program 2, second restores program 1.
    p_en = 100; p_ir = 100;
    repeat (2200) step();
    // Randomly gated enable and retire pulses.
    p_en = 80; p_ir = 60;
    repeat (4000) step();

    // Reset in the middle of SAVE_REGS.
    do_reset();
    p_en = 100; p_ir = 100; p_abort = 1; aborted = 0;
    for (int n = 0; n < 1200 && !aborted; n++) step();
    check("abort_reached", 64'(aborted), 64'd1);
    p_abort = 0;
    do_reset();
    repeat (40) step();

    // Program 1 halts first: program 2 runs alone with slice rewraps, then halts too.
    p_en = 90; p_ir = 70;
    repeat (300) step();
    p_halt = 1;
    repeat (2600) step();
    p_halt = 1;
    repeat (30) step();

    // Program 2 halts first: halt-triggered restore of program 1, then program 1 halts.
    do_reset();
    p_en = 100; p_ir = 100;
    repeat (1300) step();
    p_halt = 1;
    p_en = 85; p_ir = 50;
    repeat (1500) step();
    p_halt = 1;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
